// File: rtl/ads41_idelay_cal_pkg.sv
// ads41_cal_pkg: calibration FSM encoding, default constants and lane slicing.
package ads41_cal_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_CHECK,
    S_SCORE,
    S_CENTER,
    S_APPLY,
    S_DONE
  } cal_state_t;

  localparam int          TAP_BITS_DEF = 5;
  localparam int          MIN_EYE_DEF  = 4;
  localparam logic [11:0] PAT_A_DEF    = 12'hAAA;

  // Lane k carries bits {2k+1, 2k}; callers pass the word zero-extended to 64 bits.
  function automatic logic [1:0] lane_slice(input logic [63:0] word, input int k);
    return word[2*k +: 2];
  endfunction

endpackage

// File: rtl/ads41_idelay_cal_if.sv
// ads41_idelay_cal_if: capture-data input, start request, status and IDELAY control.
interface ads41_idelay_cal_if
  import ads41_cal_pkg::*;
#(
  parameter int NBITS    = 12,
  parameter int TAP_BITS = TAP_BITS_DEF
);
  localparam int NLANES = NBITS / 2;

  logic                start;
  logic                d_valid;
  logic [NBITS-1:0]    d_in;
  logic                busy;
  logic                done;
  logic                fail;
  logic [NLANES-1:0]   lane_fail;
  logic [TAP_BITS-1:0] dly_tap;
  logic [NLANES-1:0]   dly_load;

  modport master (
    output start, d_valid, d_in,
    input  busy, done, fail, lane_fail, dly_tap, dly_load
  );

  modport slave (
    input  start, d_valid, d_in,
    output busy, done, fail, lane_fail, dly_tap, dly_load
  );
endinterface

// File: rtl/ads41_idelay_cal_eye_tracker.sv
// ads41_eye_tracker: per-lane run tracking over the tap sweep and eye-centre pick.
// The earliest of equally long runs wins; an eye shorter than MIN_EYE marks the lane failed.
module ads41_eye_tracker
  import ads41_cal_pkg::*;
#(
  parameter int TAP_BITS = TAP_BITS_DEF,
  parameter int MIN_EYE  = MIN_EYE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                score,
  input  logic                pass,
  input  logic                center_stb,
  input  logic [TAP_BITS-1:0] tap,
  output logic [TAP_BITS-1:0] centre,
  output logic                lane_fail
);
  localparam logic [TAP_BITS:0] LEN_ONE = (TAP_BITS+1)'(1);
  localparam logic [TAP_BITS:0] LEN_MIN = (TAP_BITS+1)'(MIN_EYE);

  logic [TAP_BITS-1:0] cur_start, best_start, run_start;
  logic [TAP_BITS:0]   cur_len, best_len, run_len;

  // Start and length of the run if the current tap passes.
  always_comb begin
    run_start = (cur_len == '0) ? tap : cur_start;
    run_len   = cur_len + LEN_ONE;
  end

  // Run/best bookkeeping on score, centre and verdict on center_stb.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
      centre     <= '0;
      lane_fail  <= 1'b0;
    end else if (clr) begin
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
      centre     <= '0;
      lane_fail  <= 1'b0;
    end else begin
      if (score) begin
        if (pass) begin
          cur_start <= run_start;
          cur_len   <= run_len;
          if (run_len > best_len) begin
            best_start <= run_start;
            best_len   <= run_len;
          end
        end else begin
          cur_len <= '0;
        end
      end
      if (center_stb) begin
        if (best_len >= LEN_MIN) begin
          centre    <= best_start + TAP_BITS'((best_len - LEN_ONE) >> 1);
          lane_fail <= 1'b0;
        end else begin
          centre    <= '0;
          lane_fail <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ads41_idelay_cal.sv
// ads41_idelay_cal: sweeps a shared IDELAY tap over all lanes, scores the toggle
// pattern per lane and loads each lane with the centre of its widest eye.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   S_IDLE   | waiting for start
//   S_LOAD   | present current sweep tap to all lanes (one cycle)
//   S_SETTLE | wait SETTLE_CYCLES for the delay line to settle
//   S_CHECK  | seed on first valid, then check CHECK_CYCLES valid samples
//   S_SCORE  | fold per-lane pass/fail into the eye trackers, advance tap
//   S_CENTER | trackers compute centre and lane verdict
//   S_APPLY  | load centre into lane 0..NLANES-1, one lane per cycle
//   S_DONE   | results held; start begins a new calibration
module ads41_idelay_cal
  import ads41_cal_pkg::*;
#(
  parameter int               NBITS         = 12,
  parameter int               TAP_BITS      = TAP_BITS_DEF,
  parameter int               SETTLE_CYCLES = 64,
  parameter int               CHECK_CYCLES  = 1024,
  parameter int               MIN_EYE       = MIN_EYE_DEF,
  parameter logic [NBITS-1:0] PAT_A         = NBITS'(PAT_A_DEF)
) (
  input logic               clk,
  input logic               rst,
  ads41_idelay_cal_if.slave bus
);
  localparam int NLANES  = NBITS / 2;
  localparam int CNT_MAX = (SETTLE_CYCLES > CHECK_CYCLES) ? SETTLE_CYCLES : CHECK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int LANE_W  = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam logic [NBITS-1:0]    PAT_B   = ~PAT_A;
  localparam logic [TAP_BITS-1:0] TAP_MAX = '1;

  cal_state_t          state, state_nxt;
  logic [TAP_BITS-1:0] tap_r, dly_tap_r;
  logic [CNT_W-1:0]    cnt;
  logic [LANE_W-1:0]   lane_idx;
  logic                seeded, done_r, fail_r;
  logic                accept, score_stb, center_stb, cnt_zero, apply_last;
  logic [NBITS-1:0]    prev_word;
  logic [NLANES-1:0]   err, lane_err, lane_fail_w, dly_load_r;
  logic [TAP_BITS-1:0] centre [NLANES];

  assign accept     = bus.start && ((state == S_IDLE) || (state == S_DONE));
  assign cnt_zero   = (cnt == '0);
  assign apply_last = (lane_idx == LANE_W'(NLANES - 1));

  assign bus.busy      = (state != S_IDLE) && (state != S_DONE);
  assign bus.done      = done_r;
  assign bus.fail      = fail_r;
  assign bus.lane_fail = lane_fail_w;
  assign bus.dly_tap   = dly_tap_r;
  assign bus.dly_load  = dly_load_r;

  // A lane errs on an illegal slice or on a slice that failed to toggle.
  for (genvar k = 0; k < NLANES; k++) begin : g_lane
    logic [1:0] cur_sl;
    assign cur_sl      = lane_slice(64'(bus.d_in), k);
    assign lane_err[k] = ((cur_sl != lane_slice(64'(PAT_A), k)) &&
                          (cur_sl != lane_slice(64'(PAT_B), k))) ||
                         (cur_sl == lane_slice(64'(prev_word), k));

    ads41_eye_tracker #(
      .TAP_BITS (TAP_BITS),
      .MIN_EYE  (MIN_EYE)
    ) u_eye (
      .clk        (clk),
      .rst        (rst),
      .clr        (accept),
      .score      (score_stb),
      .pass       (!err[k]),
      .center_stb (center_stb),
      .tap        (tap_r),
      .centre     (centre[k]),
      .lane_fail  (lane_fail_w[k])
    );
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and tracker strobes.
  always_comb begin
    state_nxt  = state;
    score_stb  = 1'b0;
    center_stb = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (bus.start) state_nxt = S_LOAD;
      S_LOAD:         state_nxt = S_SETTLE;
      S_SETTLE:       if (cnt_zero) state_nxt = S_CHECK;
      S_CHECK:        if (bus.d_valid && seeded && cnt_zero) state_nxt = S_SCORE;
      S_SCORE: begin
        score_stb = 1'b1;
        state_nxt = (tap_r == TAP_MAX) ? S_CENTER : S_LOAD;
      end
      S_CENTER: begin
        center_stb = 1'b1;
        state_nxt  = S_APPLY;
      end
      S_APPLY:        if (apply_last) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Sweep tap, settle/check down-counter, error capture and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tap_r      <= '0;
      cnt        <= '0;
      lane_idx   <= '0;
      seeded     <= 1'b0;
      prev_word  <= '0;
      err        <= '0;
      dly_tap_r  <= '0;
      dly_load_r <= '0;
      done_r     <= 1'b0;
      fail_r     <= 1'b0;
    end else begin
      dly_load_r <= '0;
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            tap_r  <= '0;
            done_r <= 1'b0;
            fail_r <= 1'b0;
          end
        end
        S_LOAD: begin
          dly_tap_r  <= tap_r;
          dly_load_r <= '1;
          cnt        <= CNT_W'(SETTLE_CYCLES - 1);
          seeded     <= 1'b0;
          err        <= '0;
        end
        S_SETTLE: begin
          if (cnt_zero) cnt <= CNT_W'(CHECK_CYCLES - 1);
          else          cnt <= cnt - CNT_W'(1);
        end
        S_CHECK: begin
          if (bus.d_valid) begin
            prev_word <= bus.d_in;
            seeded    <= 1'b1;
            if (seeded) begin
              err <= err | lane_err;
              if (!cnt_zero) cnt <= cnt - CNT_W'(1);
            end
          end
        end
        S_SCORE: begin
          if (tap_r != TAP_MAX) tap_r <= tap_r + TAP_BITS'(1);
        end
        S_CENTER: lane_idx <= '0;
        S_APPLY: begin
          dly_tap_r  <= centre[lane_idx];
          dly_load_r <= NLANES'(1) << lane_idx;
          lane_idx   <= lane_idx + LANE_W'(1);
          if (apply_last) begin
            done_r <= 1'b1;
            fail_r <= |lane_fail_w;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ads41_idelay_cal.sv
// tb_ads41_idelay_cal: directed scenarios for the IDELAY calibration engine.
// A behavioural capture model corrupts chosen lanes at chosen taps.
module tb_ads41_idelay_cal;
  localparam int          NBITS    = 12;
  localparam int          TAP_BITS = 5;
  localparam int          NLANES   = 6;
  localparam logic [11:0] PAT_A    = 12'hAAA;
  localparam int          NOM_CYC  = 32 * (1 + 4 + 9 + 1) + 1 + 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  int   scen  = 0;
  bit   duty3 = 1'b0;
  int   cur_tap = 0;
  bit   phase = 1'b0;
  int   vcnt = 0;
  logic [11:0] w;
  int   applied [NLANES];
  int   order_log [8];
  int   n_apply = 0;
  int   first_tap = -1;
  int   load_pulses = 0;
  logic done_at_start;

  ads41_idelay_cal_if #(.NBITS(NBITS), .TAP_BITS(TAP_BITS)) bus ();

  ads41_idelay_cal #(
    .NBITS(NBITS), .TAP_BITS(TAP_BITS), .SETTLE_CYCLES(4), .CHECK_CYCLES(8),
    .MIN_EYE(4), .PAT_A(PAT_A)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  function automatic bit lane_bad(input int lane, input int tap);
    case (scen)
      1:       return (lane == 2) && ((tap <= 9) || (tap >= 25));
      2:       return (lane == 4);
      3:       return ((lane == 0) && !(((tap >= 2) && (tap <= 6)) || ((tap >= 20) && (tap <= 24)))) ||
                      ((lane == 3) && !((tap >= 10) && (tap <= 13)));
      4:       return ((lane == 0) && !((tap >= 7) && (tap <= 9))) || ((lane == 5) && (tap < 28));
      default: return 1'b0;
    endcase
  endfunction

  // Capture model plus load monitor, stepping just after each rising edge.
  initial begin
    bus.start   = 1'b0;
    bus.d_valid = 1'b0;
    bus.d_in    = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.dly_load != '0) load_pulses++;
      if (bus.dly_load == '1) begin
        cur_tap = int'(bus.dly_tap);
        if (first_tap < 0) first_tap = int'(bus.dly_tap);
      end else if (bus.dly_load != '0) begin
        for (int k = 0; k < NLANES; k++)
          if (bus.dly_load[k]) begin
            applied[k] = int'(bus.dly_tap);
            if (n_apply < 8) order_log[n_apply] = k;
          end
        n_apply++;
      end
      vcnt = (vcnt == 2) ? 0 : vcnt + 1;
      if (!duty3 || (vcnt == 0)) begin
        phase = !phase;
        w = phase ? PAT_A : ~PAT_A;
        for (int k = 0; k < NLANES; k++) begin
          if (lane_bad(k, cur_tap))
            w[2*k +: 2] = phase ? 2'b00 : 2'b11;
          else if ((scen == 5) && (k == 1) && (cur_tap == 12))
            w[2*k +: 2] = 2'b10;
        end
        bus.d_valid = 1'b1;
        bus.d_in    = w;
      end else begin
        bus.d_valid = 1'b0;
        bus.d_in    = 12'hFFF;
      end
    end
  end

  task automatic run_cal(input int poke_at, output int busy_cyc);
    @(negedge clk);
    n_apply   = 0;
    first_tap = -1;
    for (int k = 0; k < NLANES; k++) applied[k] = -1;
    for (int k = 0; k < 8; k++) order_log[k] = -1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
    done_at_start = bus.done;
    busy_cyc = 0;
    while (bus.busy && (busy_cyc < 4000)) begin
      busy_cyc++;
      bus.start = (busy_cyc == poke_at);
      @(negedge clk);
    end
    bus.start = 1'b0;
    checks++;
    if (busy_cyc >= 4000) begin
      errors++;
      $display("FAIL cal_timeout busy_cycles=%0d limit=4000", busy_cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.fail !== 1'b0) begin errors++; $display("FAIL reset_fail got=%b exp=0", bus.fail); end
    checks++; if (bus.lane_fail !== 6'b0) begin errors++; $display("FAIL reset_lane_fail got=%b exp=000000", bus.lane_fail); end
    checks++; if (bus.dly_tap !== 5'd0) begin errors++; $display("FAIL reset_dly_tap got=%0d exp=0", bus.dly_tap); end
    checks++; if (bus.dly_load !== 6'b0) begin errors++; $display("FAIL reset_dly_load got=%b exp=000000", bus.dly_load); end
  endtask

  task automatic test_clean();
    int bc;
    scen = 0; duty3 = 1'b0;
    run_cal(-1, bc);
    checks++; if (bc !== NOM_CYC) begin errors++; $display("FAIL clean_duration got=%0d exp=%0d", bc, NOM_CYC); end
    checks++; if (first_tap !== 0) begin errors++; $display("FAIL clean_first_tap got=%0d exp=0", first_tap); end
    checks++; if (n_apply !== NLANES) begin errors++; $display("FAIL clean_apply_count got=%0d exp=%0d", n_apply, NLANES); end
    for (int k = 0; k < NLANES; k++) begin
      checks++; if (order_log[k] !== k) begin errors++; $display("FAIL clean_apply_order idx=%0d got=%0d exp=%0d", k, order_log[k], k); end
      checks++; if (applied[k] !== 15) begin errors++; $display("FAIL clean_centre lane=%0d got=%0d exp=15", k, applied[k]); end
    end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL clean_done got=%b exp=1", bus.done); end
    checks++; if (bus.fail !== 1'b0) begin errors++; $display("FAIL clean_fail got=%b exp=0", bus.fail); end
    checks++; if (bus.lane_fail !== 6'b0) begin errors++; $display("FAIL clean_lane_fail got=%b exp=000000", bus.lane_fail); end
    checks++; if (bus.dly_tap !== 5'd15) begin errors++; $display("FAIL clean_dly_tap_hold got=%0d exp=15", bus.dly_tap); end
  endtask

  task automatic test_lane2_edges();
    int bc;
    scen = 1;
    run_cal(-1, bc);
    checks++; if (done_at_start !== 1'b0) begin errors++; $display("FAIL lane2_done_cleared got=%b exp=0", done_at_start); end
    checks++; if (applied[2] !== 17) begin errors++; $display("FAIL lane2_centre got=%0d exp=17", applied[2]); end
    checks++; if (applied[5] !== 15) begin errors++; $display("FAIL lane2_other_centre got=%0d exp=15", applied[5]); end
    checks++; if (bus.fail !== 1'b0) begin errors++; $display("FAIL lane2_fail got=%b exp=0", bus.fail); end
  endtask

  task automatic test_lane4_dead();
    int bc;
    scen = 2;
    run_cal(-1, bc);
    checks++; if (bus.lane_fail !== 6'b010000) begin errors++; $display("FAIL lane4_lane_fail got=%b exp=010000", bus.lane_fail); end
    checks++; if (applied[4] !== 0) begin errors++; $display("FAIL lane4_centre got=%0d exp=0", applied[4]); end
    checks++; if (applied[3] !== 15) begin errors++; $display("FAIL lane4_neighbour got=%0d exp=15", applied[3]); end
    checks++; if (bus.fail !== 1'b1) begin errors++; $display("FAIL lane4_fail got=%b exp=1", bus.fail); end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL lane4_done got=%b exp=1", bus.done); end
  endtask

  task automatic test_eye_boundaries();
    int bc;
    scen = 3;
    run_cal(-1, bc);
    checks++; if (applied[0] !== 4) begin errors++; $display("FAIL tie_earlier_eye got=%0d exp=4", applied[0]); end
    checks++; if (applied[3] !== 11) begin errors++; $display("FAIL min_eye_len4 got=%0d exp=11", applied[3]); end
    checks++; if (bus.lane_fail !== 6'b0) begin errors++; $display("FAIL tie_lane_fail got=%b exp=000000", bus.lane_fail); end
    scen = 4;
    run_cal(-1, bc);
    checks++; if (bus.lane_fail !== 6'b000001) begin errors++; $display("FAIL short_eye_lane_fail got=%b exp=000001", bus.lane_fail); end
    checks++; if (applied[0] !== 0) begin errors++; $display("FAIL short_eye_centre got=%0d exp=0", applied[0]); end
    checks++; if (applied[5] !== 29) begin errors++; $display("FAIL top_run_centre got=%0d exp=29", applied[5]); end
    checks++; if (bus.fail !== 1'b1) begin errors++; $display("FAIL short_eye_fail got=%b exp=1", bus.fail); end
  endtask

  task automatic test_valid_duty();
    int bc;
    scen = 5; duty3 = 1'b1;
    run_cal(-1, bc);
    duty3 = 1'b0;
    checks++; if ((bc < 999) || (bc > 1063)) begin errors++; $display("FAIL duty_duration got=%0d exp=999..1063", bc); end
    checks++; if (applied[1] !== 22) begin errors++; $display("FAIL stuck_lane1_centre got=%0d exp=22", applied[1]); end
    checks++; if (applied[0] !== 15) begin errors++; $display("FAIL duty_lane0_centre got=%0d exp=15", applied[0]); end
    checks++; if (bus.lane_fail !== 6'b0) begin errors++; $display("FAIL duty_lane_fail got=%b exp=000000", bus.lane_fail); end
  endtask

  task automatic test_back_to_back();
    int bc;
    scen = 0;
    run_cal(100, bc);
    checks++; if (bc !== NOM_CYC) begin errors++; $display("FAIL midstart_duration got=%0d exp=%0d", bc, NOM_CYC); end
    checks++; if (applied[0] !== 15) begin errors++; $display("FAIL midstart_centre got=%0d exp=15", applied[0]); end
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (52) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midcheck_busy got=%b exp=1", bus.busy); end
    checks++; if (bus.dly_tap !== 5'd3) begin errors++; $display("FAIL midcheck_tap got=%0d exp=3", bus.dly_tap); end
    rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.dly_tap !== 5'd0) begin errors++; $display("FAIL rst_dly_tap got=%0d exp=0", bus.dly_tap); end
    checks++; if (bus.dly_load !== 6'b0) begin errors++; $display("FAIL rst_dly_load got=%b exp=000000", bus.dly_load); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", bus.done); end
    load_pulses = 0;
    repeat (5) @(negedge clk);
    checks++; if (load_pulses !== 0) begin errors++; $display("FAIL rst_no_load got=%0d exp=0", load_pulses); end
    rst = 1'b0;
    @(negedge clk);
    run_cal(-1, bc);
    checks++; if (bc !== NOM_CYC) begin errors++; $display("FAIL rerun_duration got=%0d exp=%0d", bc, NOM_CYC); end
    checks++; if (first_tap !== 0) begin errors++; $display("FAIL rerun_first_tap got=%0d exp=0", first_tap); end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL rerun_done got=%b exp=1", bus.done); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_lane2_edges();
    test_lane4_dead();
    test_eye_boundaries();
    test_valid_duty();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
